// File: rtl/seq_mul_shift_add.sv
// seq_mul_shift_add -- multi-cycle shift-add multiplier for the ALU datapath.
//
// Computes a WIDTH x WIDTH -> 2*WIDTH product with one partial-product add
// per cycle. Latency is fixed at WIDTH iterations plus the DONE cycle,
// whatever the operand values are.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request, sampled only in IDLE or DONE
//   a          in   [WIDTH-1:0]   multiplicand, captured on accepted start
//   b          in   [WIDTH-1:0]   multiplier, captured on accepted start
//   is_signed  in   two's-complement select (used only with SEQ_MUL_SIGNED_EN)
//   busy       out  high while iterating (RUN)
//   done       out  one-cycle pulse when product is updated
//   product    out  [2*WIDTH-1:0] result, held until the next result is written
//
// Build option: define SEQ_MUL_SIGNED_EN to compile in signed mode
// (magnitudes at capture, negate on completion when the operand signs differ).
// Without it, is_signed is ignored and no sign/negate logic exists.
module seq_mul_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;     // {upper, lower}; lower holds remaining multiplier bits
  logic [WIDTH-1:0]     mcand;
  logic [CW-1:0]        cnt;

  logic                 accept;
  logic [WIDTH:0]       sum;     // one extra bit so the carry of the add survives the shift
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   result;

  assign accept = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  end

`ifdef SEQ_MUL_SIGNED_EN
  logic neg;      // captured: final result must be negated
  logic neg_in;

  // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude.
  always_comb begin
    a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
    neg_in = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    result = neg ? -acc : acc;
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      case (state)
        RUN: begin
          // Add (if the current multiplier bit is set), then shift the
          // whole {carry, upper, lower} right by one.
          acc <= {sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          product <= result;
          done    <= 1'b1;
        end
        default: ;
      endcase

      // A start in DONE overrides the return to IDLE (back-to-back issue).
      if (accept) begin
        mcand <= a_mag;
        acc   <= {{WIDTH{1'b0}}, b_mag};
        cnt   <= '0;
        state <= RUN;
        busy  <= 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
        neg   <= neg_in;
`endif
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Testbench for seq_mul_shift_add: one WIDTH=8 and one WIDTH=32 instance,
// a timeline/arithmetic reference model, a per-cycle compare process and
// directed transactions with literal expected products.
module tb_seq_mul_shift_add;

  logic        clk;
  logic        rst_n;
  logic        start_i [2];
  logic [31:0] a_i     [2];
  logic [31:0] b_i     [2];
  logic        sgn_i   [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic [63:0] prod_o  [2];
  logic [15:0] p8;
  logic [63:0] p32;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  seq_mul_shift_add #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]),
    .a(a_i[0][7:0]), .b(b_i[0][7:0]), .is_signed(sgn_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .product(p8)
  );

  seq_mul_shift_add #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]),
    .a(a_i[1]), .b(b_i[1]), .is_signed(sgn_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .product(p32)
  );

  assign prod_o[0] = {48'b0, p8};
  assign prod_o[1] = p32;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Mathematical product of the captured operands.
  function automatic logic [63:0] expect_prod(input int i, input logic [31:0] av,
                                              input logic [31:0] bv, input logic sg);
    logic [63:0] r;
    longint      x, y;
    r = (i == 1) ? (64'(av) * 64'(bv)) : (64'(av[7:0]) * 64'(bv[7:0]));
`ifdef SEQ_MUL_SIGNED_EN
    if (sg) begin
      x = (i == 1) ? longint'($signed(av)) : longint'($signed(av[7:0]));
      y = (i == 1) ? longint'($signed(bv)) : longint'($signed(bv[7:0]));
      r = 64'(x * y);
    end
`else
    if (sg) r = r;
`endif
    if (i == 0) r = r & 64'hFFFF;
    return r;
  endfunction

  // Timeline: an accepted start schedules the result W+1 edges later;
  // busy covers the first W of them.
  int          m_left [2];
  logic        m_busy [2];
  logic        m_done [2];
  logic [63:0] m_prod [2];
  logic [63:0] m_pend [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_left[i] <= 0;
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_prod[i] <= '0;
        m_pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= (m_left[i] == 1);
        if (m_left[i] == 1) m_prod[i] <= m_pend[i];
        if (start_i[i] && !m_busy[i]) begin
          m_pend[i] <= expect_prod(i, a_i[i], b_i[i], sgn_i[i]);
          m_left[i] <= (i == 1) ? 33 : 9;
          m_busy[i] <= 1'b1;
        end else begin
          m_left[i] <= (m_left[i] > 0) ? m_left[i] - 1 : 0;
          m_busy[i] <= (m_left[i] >= 3);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        checks = checks + 3;
        if (busy_o[i] !== m_busy[i]) begin
          errors++;
          $display("FAIL cyc busy[%0d] @%0t: got %b expected %b", i, $time, busy_o[i], m_busy[i]);
        end
        if (done_o[i] !== m_done[i]) begin
          errors++;
          $display("FAIL cyc done[%0d] @%0t: got %b expected %b", i, $time, done_o[i], m_done[i]);
        end
        if (prod_o[i] !== m_prod[i]) begin
          errors++;
          $display("FAIL cyc product[%0d] @%0t: got %h expected %h", i, $time, prod_o[i], m_prod[i]);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete transaction: pulse start, then scramble a/b and wait for done.
  task automatic mul(input int i, input logic [31:0] av, input logic [31:0] bv,
                     input logic sg, input logic [63:0] exp_p, input string nm);
    int k;
    int nb;
    int w;
    w = (i == 1) ? 32 : 8;
    @(negedge clk);
    a_i[i] = av; b_i[i] = bv; sgn_i[i] = sg; start_i[i] = 1'b1;
    @(negedge clk);
    start_i[i] = 1'b0;
    a_i[i] = ~av; b_i[i] = bv + 32'd1;
    k = 1; nb = 0;
    while (!done_o[i] && k < 200) begin
      if (busy_o[i]) nb++;
      @(negedge clk);
      k++;
    end
    check({nm, " latency"}, 64'(k), 64'(w + 2));
    check({nm, " busy_cycles"}, 64'(nb), 64'(w));
    check({nm, " product"}, prod_o[i], exp_p);
    check({nm, " model"}, m_prod[i], exp_p);
    $display("txn %s: W=%0d a=%h b=%h s=%b product=%h latency=%0d", nm, w, av, bv, sg, prod_o[i], k);
  endtask

  initial begin
    int k;
    int nd;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0; a_i[i] = '0; b_i[i] = '0; sgn_i[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset busy", 64'(busy_o[i]), 64'd0);
      check("reset done", 64'(done_o[i]), 64'd0);
      check("reset product", prod_o[i], 64'd0);
    end
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Basic and carry-path products at WIDTH=32.
    mul(1, 32'd3, 32'd5, 1'b0, 64'd15, "w32_3x5");
    mul(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, "w32_max");

    // Zero multiplier at WIDTH=8, with an ignored start during busy.
    @(negedge clk);
    a_i[0] = 32'hAB; b_i[0] = 32'h00; sgn_i[0] = 1'b0; start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    k = 1;
    repeat (2) begin @(negedge clk); k++; end
    a_i[0] = 32'h02; b_i[0] = 32'h02; start_i[0] = 1'b1;
    @(negedge clk); k++;
    start_i[0] = 1'b0;
    while (!done_o[0] && k < 200) begin @(negedge clk); k++; end
    check("w8_zero latency", 64'(k), 64'd10);
    check("w8_zero product", prod_o[0], 64'd0);
    nd = 0;
    repeat (15) begin @(negedge clk); if (done_o[0]) nd++; end
    check("w8_ignored no_done", 64'(nd), 64'd0);
    check("w8_ignored product", prod_o[0], 64'd0);
    $display("txn w8_zero_ignored: a=ab b=00 product=%h latency=%0d", prod_o[0], k);

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    a_i[0] = 32'd12; b_i[0] = 32'd10; start_i[0] = 1'b1;
    @(negedge clk);
    a_i[0] = 32'd7; b_i[0] = 32'd9;
    k = 1;
    while (!done_o[0] && k < 200) begin @(negedge clk); k++; end
    start_i[0] = 1'b0;
    check("b2b first latency", 64'(k), 64'd10);
    check("b2b first product", prod_o[0], 64'd120);
    $display("txn b2b_first: a=12 b=10 product=%0d latency=%0d", prod_o[0], k);
    @(negedge clk); k++;
    while (!done_o[0] && k < 200) begin @(negedge clk); k++; end
    check("b2b second latency", 64'(k), 64'd19);
    check("b2b second product", prod_o[0], 64'd63);
    $display("txn b2b_second: a=7 b=9 product=%0d latency=%0d", prod_o[0], k);

    // Asynchronous reset in the middle of a WIDTH=32 multiply.
    @(negedge clk);
    a_i[1] = 32'd5; b_i[1] = 32'd6; start_i[1] = 1'b1;
    @(negedge clk);
    start_i[1] = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst busy", 64'(busy_o[1]), 64'd0);
    check("async_rst done", 64'(done_o[1]), 64'd0);
    check("async_rst product", prod_o[1], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin @(negedge clk); if (done_o[1]) nd++; end
    check("async_rst no_done", 64'(nd), 64'd0);
    $display("txn reset_abort: product=%h done_pulses=%0d", prod_o[1], nd);
    mul(1, 32'd9, 32'd9, 1'b0, 64'd81, "w32_after_rst");

    // Sign handling at WIDTH=8 (unsigned interpretation without the option).
`ifdef SEQ_MUL_SIGNED_EN
    mul(0, 32'hFD, 32'h07, 1'b1, 64'hFFEB, "w8_s_m3x7");
`else
    mul(0, 32'hFD, 32'h07, 1'b1, 64'h06EB, "w8_s_m3x7");
`endif
    mul(0, 32'h80, 32'h80, 1'b1, 64'h4000, "w8_s_80x80");
    mul(0, 32'h80, 32'h80, 1'b0, 64'h4000, "w8_u_80x80");
    mul(0, 32'hFF, 32'h02, 1'b0, 64'h01FE, "w8_u_ffx02");
    mul(0, 32'hFF, 32'hFF, 1'b0, 64'hFE01, "w8_u_max");

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_mul_shift_add.md
Name: seq_mul_shift_add

Overview:
- Parametrised multi-cycle shift-add multiplier for the ALU datapath: WIDTH x WIDTH operands in, 2*WIDTH-bit product out.
- Handshake: start/busy/done, for the controller sequencing multi-cycle ALU ops.
- Unsigned by default; signed mode is compiled in by macro.
- One partial-product add per cycle; no combinational multiplier array.

Parameters:
- WIDTH, 32, operand width in bits; legal range 4..64. Product width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  multiplicand; captured on accepted start
- b  input  WIDTH  multiplier; captured on accepted start
- is_signed  input  1  two's-complement mode select; captured on accepted start; honoured only with the macro
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse when product becomes valid
- product  output  2*WIDTH  result; held stable until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, product=0, internal accumulator and counter=0.
- Reset mid-operation aborts the multiply. After release the block is in IDLE with no done pulse.
- States:
  - IDLE: start=1 captures a, b, is_signed. Accumulator {upper=0, lower=multiplier}. Counter=0. Go to RUN.
  - RUN: each cycle:
    - If acc[0]=1, upper = upper + multiplicand, computed at WIDTH+1 bits to keep the carry.
    - Shift {carry, upper, lower} right by 1.
    - counter++.
    - After WIDTH iterations (counter==WIDTH-1 on the last), go to DONE.
  - DONE: product <= final accumulator (sign-corrected if applicable); done=1 for exactly this cycle. If start=1 in this cycle, capture new operands and go to RUN (back-to-back); otherwise go to IDLE.
- Latency: start sampled at edge N, so busy=1 from after edge N. The product register and done are updated at edge N+WIDTH+1, i.e. done is high during the cycle following that edge.
- busy=1 in RUN only. busy=0 in IDLE and DONE.
- start while busy is ignored, with no queuing, and operands are not recaptured.
- product changes only on entry to DONE. Otherwise it holds its value, including across IDLE.
- Carry out of the WIDTH-bit add must not be lost. The max unsigned result, (2^W-1)^2, must be exact.
- Zero operands still take the full WIDTH iterations; latency is fixed and data-independent.
- a and b may change freely after the start cycle without effect.

Optional Feature:
- Macro: SEQ_MUL_SIGNED_EN.
- When defined and the captured is_signed=1:
  - Operands are converted to magnitudes at capture.
  - The unsigned core runs unchanged.
  - The 2*WIDTH result is negated in DONE if the operand signs differ.
  - Latency is unchanged.
  - -2^(W-1) * -2^(W-1) = +2^(2W-2) must be exact.
- When defined and is_signed=0: operation is unsigned.
- When not defined: is_signed is ignored, all operations are unsigned, and no sign/negate logic is synthesised.

Test Plan:
- WIDTH=32: reset, start with a=3, b=5 -> busy=1 for 32 cycles; done pulses at edge N+33; product=64'd15; busy=0.
- WIDTH=32: a=b=32'hFFFFFFFF unsigned -> product=64'hFFFFFFFE00000001 (carry path).
- WIDTH=8: a=8'hAB, b=8'h00 -> full 8-cycle latency, product=16'h0000. Then start during busy with a=b=8'h02 -> ignored, product stays 0.
- WIDTH=8, back-to-back: start held high through DONE with a=12, b=10 then a=7, b=9 -> done at edges N+9 and N+18; products 120 then 63.
- Assert rst_n low at cycle 10 of a WIDTH=32 multiply -> busy, done and product go to 0 immediately; no done pulse afterwards; a new start works normally.
- SEQ_MUL_SIGNED_EN defined, WIDTH=8:
  - is_signed=1, a=-3, b=7 -> product=16'hFFEB (-21).
  - a=b=8'h80 -> 16'h4000.
  - is_signed=0, a=8'h80, b=8'h80 -> 16'h4000; a=8'hFF, b=8'h02 -> 16'h01FE.
